axi_rd_arbiter: RTL and testbench

Arbitrates the single AXI3 read channel (AR + R) among three CPU-side read masters: instruction cache, data cache and uncached loader. Each master raises `*_req` and waits for `*_grnt` before driving AR. Once granted, the master owns the bus until it drops `*_req` and all of its read bursts have drained. The block sits between the MEM/IF-stage memory clients and the AXI bridge.

---
 rtl/axi_rd_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares the single AXI3 read channel (AR + R) among the
// instruction cache, data cache and uncached loader. The owner holds the bus
// until it drops its request and all of its bursts have returned rlast.
// Optional feature: define AXI_RD_ARB_RR_EN for round-robin arbitration;
// without it, arbitration is fixed priority uncached > dcache > icache.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests
// OWN   | owner issues ARs, at most MAX_OUTS bursts in flight
// DRAIN | owner dropped req; AR blocked, waiting for its bursts to finish
// GAP   | one cycle with no grant so the next owner sees a clean grant edge
module axi_rd_arbiter #(
    parameter int MAX_OUTS = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        icache_req,
    output logic        icache_grnt,
    input  logic [3:0]  icache_arid,
    input  logic [31:0] icache_araddr,
    input  logic [3:0]  icache_arlen,
    input  logic [2:0]  icache_arsize,
    input  logic [1:0]  icache_arburst,
    input  logic [1:0]  icache_arlock,
    input  logic [3:0]  icache_arcache,
    input  logic [2:0]  icache_arprot,
    input  logic        icache_arvalid,
    output logic        icache_arready,
    output logic [3:0]  icache_rid,
    output logic [31:0] icache_rdata,
    output logic [1:0]  icache_rresp,
    output logic        icache_rlast,
    output logic        icache_rvalid,
    input  logic        icache_rready,

    input  logic        dcache_req,
    output logic        dcache_grnt,
    input  logic [3:0]  dcache_arid,
    input  logic [31:0] dcache_araddr,
    input  logic [3:0]  dcache_arlen,
    input  logic [2:0]  dcache_arsize,
    input  logic [1:0]  dcache_arburst,
    input  logic [1:0]  dcache_arlock,
    input  logic [3:0]  dcache_arcache,
    input  logic [2:0]  dcache_arprot,
    input  logic        dcache_arvalid,
    output logic        dcache_arready,
    output logic [3:0]  dcache_rid,
    output logic [31:0] dcache_rdata,
    output logic [1:0]  dcache_rresp,
    output logic        dcache_rlast,
    output logic        dcache_rvalid,
    input  logic        dcache_rready,

    input  logic        uncached_req,
    output logic        uncached_grnt,
    input  logic [3:0]  uncached_arid,
    input  logic [31:0] uncached_araddr,
    input  logic [3:0]  uncached_arlen,
    input  logic [2:0]  uncached_arsize,
    input  logic [1:0]  uncached_arburst,
    input  logic [1:0]  uncached_arlock,
    input  logic [3:0]  uncached_arcache,
    input  logic [2:0]  uncached_arprot,
    input  logic        uncached_arvalid,
    output logic        uncached_arready,
    output logic [3:0]  uncached_rid,
    output logic [31:0] uncached_rdata,
    output logic [1:0]  uncached_rresp,
    output logic        uncached_rlast,
    output logic        uncached_rvalid,
    input  logic        uncached_rready,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] MaxOuts = 2'(MAX_OUTS);

    typedef enum logic [1:0] {IDLE, OWN, DRAIN, GAP} state_t;

    state_t     state, stateNext;
    logic [2:0] gsel, gselNext;
    logic [2:0] reqVec, arvalidVec, rreadyVec, winner;
    logic [1:0] outs;
    logic       ownerReq, atLimit, arOpen, arHs, rLastHs;

    // Bit order everywhere: [2]=uncached, [1]=dcache, [0]=icache.
    assign reqVec     = {uncached_req, dcache_req, icache_req};
    assign arvalidVec = {uncached_arvalid, dcache_arvalid, icache_arvalid};
    assign rreadyVec  = {uncached_rready, dcache_rready, icache_rready};

    assign ownerReq = |(reqVec & gsel);
    assign atLimit  = (outs == MaxOuts);
    assign arOpen   = (state == OWN) && !atLimit;
    assign arvalid  = arOpen && |(gsel & arvalidVec);
    assign rready   = |(gsel & rreadyVec);
    assign arHs     = arvalid && arready;
    assign rLastHs  = rvalid && rready && rlast;

    // Lowest-ranked candidate is applied first so the highest-ranked one wins.
    function automatic logic [2:0] pick3(input logic [2:0] req, input logic [1:0] first,
                                         input logic [1:0] second, input logic [1:0] third);
        pick3 = 3'b000;
        if (req[third])  pick3 = 3'b001 << third;
        if (req[second]) pick3 = 3'b001 << second;
        if (req[first])  pick3 = 3'b001 << first;
    endfunction

`ifdef AXI_RD_ARB_RR_EN
    logic [2:0] rrPtr;

    // The master granted last ranks lowest; the others follow uncached -> dcache -> icache.
    always_comb begin
        winner = 3'b000;
        case (rrPtr)
            3'b100:  winner = pick3(reqVec, 2'd1, 2'd0, 2'd2);
            3'b010:  winner = pick3(reqVec, 2'd0, 2'd2, 2'd1);
            default: winner = pick3(reqVec, 2'd2, 2'd1, 2'd0);
        endcase
    end

    // Pointer remembers the most recent grant; reset value makes uncached lead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr <= 3'b001;
        end else if (state == IDLE && |reqVec) begin
            rrPtr <= winner;
        end
    end
`else
    // Fixed priority: uncached > dcache > icache.
    always_comb begin
        winner = pick3(reqVec, 2'd2, 2'd1, 2'd0);
    end
`endif

    // State and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gsel  <= 3'b000;
        end else begin
            state <= stateNext;
            gsel  <= gselNext;
        end
    end

    // Next-state: grant, hold while bursts are in flight, then one idle gap.
    always_comb begin
        stateNext = state;
        gselNext  = gsel;
        case (state)
            IDLE: begin
                gselNext = 3'b000;
                if (|reqVec) begin
                    stateNext = OWN;
                    gselNext  = winner;
                end
            end
            OWN: begin
                if (!ownerReq) begin
                    // An AR accepted in the release cycle still has to drain.
                    if (outs == 2'd0 && !arHs) begin
                        stateNext = GAP;
                        gselNext  = 3'b000;
                    end else begin
                        stateNext = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outs == 2'd0 || (outs == 2'd1 && rLastHs)) begin
                    stateNext = GAP;
                    gselNext  = 3'b000;
                end
            end
            GAP: begin
                stateNext = IDLE;
                gselNext  = 3'b000;
            end
            default: begin
                stateNext = IDLE;
                gselNext  = 3'b000;
            end
        endcase
    end

    // Bursts in flight for the current owner; saturates rather than wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outs <= 2'd0;
        end else if (arHs && !rLastHs) begin
            outs <= outs + 2'd1;
        end else if (rLastHs && !arHs && outs != 2'd0) begin
            outs <= outs - 2'd1;
        end
    end

    // AR payload from the owner; all zeros when nobody owns the bus.
    always_comb begin
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        arlock  = '0;
        arcache = '0;
        arprot  = '0;
        if (gsel[2]) begin
            arid = uncached_arid;       araddr = uncached_araddr;
            arlen = uncached_arlen;     arsize = uncached_arsize;
            arburst = uncached_arburst; arlock = uncached_arlock;
            arcache = uncached_arcache; arprot = uncached_arprot;
        end else if (gsel[1]) begin
            arid = dcache_arid;         araddr = dcache_araddr;
            arlen = dcache_arlen;       arsize = dcache_arsize;
            arburst = dcache_arburst;   arlock = dcache_arlock;
            arcache = dcache_arcache;   arprot = dcache_arprot;
        end else if (gsel[0]) begin
            arid = icache_arid;         araddr = icache_araddr;
            arlen = icache_arlen;       arsize = icache_arsize;
            arburst = icache_arburst;   arlock = icache_arlock;
            arcache = icache_arcache;   arprot = icache_arprot;
        end
    end

    assign icache_grnt   = gsel[0];
    assign dcache_grnt   = gsel[1];
    assign uncached_grnt = gsel[2];

    assign icache_arready   = arOpen && gsel[0] && arready;
    assign dcache_arready   = arOpen && gsel[1] && arready;
    assign uncached_arready = arOpen && gsel[2] && arready;

    assign icache_rvalid   = gsel[0] && rvalid;
    assign dcache_rvalid   = gsel[1] && rvalid;
    assign uncached_rvalid = gsel[2] && rvalid;

    // R payload is broadcast; only rvalid marks it as meant for the owner.
    assign icache_rid     = rid;
    assign icache_rdata   = rdata;
    assign icache_rresp   = rresp;
    assign icache_rlast   = rlast;
    assign dcache_rid     = rid;
    assign dcache_rdata   = rdata;
    assign dcache_rresp   = rresp;
    assign dcache_rlast   = rlast;
    assign uncached_rid   = rid;
    assign uncached_rdata = rdata;
    assign uncached_rresp = rresp;
    assign uncached_rlast = rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter with a transaction-level reference
// model: who owns the bus, how many bursts are in flight, and how many idle
// cycles must pass before the next grant. Honors AXI_RD_ARB_RR_EN.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    localparam int MAXO   = 3;
    localparam int NCYCLE = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Index 0 = icache, 1 = dcache, 2 = uncached.
    logic [2:0]        mReq, mGrnt, mArvalid, mArready, mRvalid, mRready, mRlast;
    logic [2:0][3:0]   mArid, mArlen, mArcache, mRid;
    logic [2:0][31:0]  mAraddr, mRdata;
    logic [2:0][2:0]   mArsize, mArprot;
    logic [2:0][1:0]   mArburst, mArlock, mRresp;

    logic [3:0]  arid, arlen, arcache, rid;
    logic [31:0] araddr, rdata;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi_rd_arbiter #(.MAX_OUTS(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_req(mReq[0]), .icache_grnt(mGrnt[0]),
        .icache_arid(mArid[0]), .icache_araddr(mAraddr[0]), .icache_arlen(mArlen[0]),
        .icache_arsize(mArsize[0]), .icache_arburst(mArburst[0]), .icache_arlock(mArlock[0]),
        .icache_arcache(mArcache[0]), .icache_arprot(mArprot[0]),
        .icache_arvalid(mArvalid[0]), .icache_arready(mArready[0]),
        .icache_rid(mRid[0]), .icache_rdata(mRdata[0]), .icache_rresp(mRresp[0]),
        .icache_rlast(mRlast[0]), .icache_rvalid(mRvalid[0]), .icache_rready(mRready[0]),
        .dcache_req(mReq[1]), .dcache_grnt(mGrnt[1]),
        .dcache_arid(mArid[1]), .dcache_araddr(mAraddr[1]), .dcache_arlen(mArlen[1]),
        .dcache_arsize(mArsize[1]), .dcache_arburst(mArburst[1]), .dcache_arlock(mArlock[1]),
        .dcache_arcache(mArcache[1]), .dcache_arprot(mArprot[1]),
        .dcache_arvalid(mArvalid[1]), .dcache_arready(mArready[1]),
        .dcache_rid(mRid[1]), .dcache_rdata(mRdata[1]), .dcache_rresp(mRresp[1]),
        .dcache_rlast(mRlast[1]), .dcache_rvalid(mRvalid[1]), .dcache_rready(mRready[1]),
        .uncached_req(mReq[2]), .uncached_grnt(mGrnt[2]),
        .uncached_arid(mArid[2]), .uncached_araddr(mAraddr[2]), .uncached_arlen(mArlen[2]),
        .uncached_arsize(mArsize[2]), .uncached_arburst(mArburst[2]), .uncached_arlock(mArlock[2]),
        .uncached_arcache(mArcache[2]), .uncached_arprot(mArprot[2]),
        .uncached_arvalid(mArvalid[2]), .uncached_arready(mArready[2]),
        .uncached_rid(mRid[2]), .uncached_rdata(mRdata[2]), .uncached_rresp(mRresp[2]),
        .uncached_rlast(mRlast[2]), .uncached_rvalid(mRvalid[2]), .uncached_rready(mRready[2]),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int nTests = 0;
    int nFail  = 0;

    // Reference model state.
    int owner     = -1;   // -1: bus free
    bit releasing = 1'b0; // owner dropped req, waiting for its bursts
    int inFlight  = 0;    // bursts issued and not yet finished
    int holdOff   = 0;    // edges to skip before arbitration may happen again
    int lastGrant = 0;    // most recent grant (icache at reset)
    int beatQ[$];         // bridge: beats still to return per accepted burst

    // Stimulus state per master.
    int burstsLeft [3];
    bit issuing [3];

    task automatic chkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [53:0] masterAr(input int i);
        return {mArid[i], mAraddr[i], mArlen[i], mArsize[i], mArburst[i],
                mArlock[i], mArcache[i], mArprot[i]};
    endfunction

    function automatic bit arAllowed();
        return owner >= 0 && !releasing && inFlight < MAXO;
    endfunction

    // Next owner among requesters: fixed order, or rotation away from the last grant.
    function automatic int arbitrate();
`ifdef AXI_RD_ARB_RR_EN
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (lastGrant - k + 3) % 3;
            if (mReq[idx]) return idx;
        end
`else
        for (int idx = 2; idx >= 0; idx--) begin
            if (mReq[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic randomAr(input int i);
        mArid[i]    = 4'($urandom);
        mAraddr[i]  = $urandom;
        mArlen[i]   = 4'($urandom_range(0, 7));
        mArsize[i]  = 3'($urandom);
        mArburst[i] = 2'($urandom);
        mArlock[i]  = 2'($urandom);
        mArcache[i] = 4'($urandom);
        mArprot[i]  = 3'($urandom);
    endtask

    // Drive masters and bridge for the coming cycle (called just after negedge).
    task automatic driveInputs();
        for (int i = 0; i < 3; i++) begin
            if (owner == i && !releasing && mReq[i]) begin
                if (!issuing[i]) begin
                    if (burstsLeft[i] > 0 && $urandom_range(0, 1) == 1) begin
                        issuing[i]  = 1'b1;
                        mArvalid[i] = 1'b1;
                        randomAr(i);
                    end else begin
                        mArvalid[i] = 1'b0;
                        randomAr(i);
                        if (burstsLeft[i] == 0 && $urandom_range(0, 3) == 0) mReq[i] = 1'b0;
                    end
                end
            end else begin
                // Not an active owner: junk AR traffic that must never reach the bus.
                issuing[i]  = 1'b0;
                mArvalid[i] = 1'($urandom);
                randomAr(i);
                if (!mReq[i] && $urandom_range(0, 5) == 0) begin
                    mReq[i]       = 1'b1;
                    burstsLeft[i] = $urandom_range(0, 4);
                end
            end
            mRready[i] = ($urandom_range(0, 3) != 0);
        end
        arready = ($urandom_range(0, 3) != 0);
        rid     = 4'($urandom);
        rdata   = $urandom;
        rresp   = 2'($urandom);
        if (beatQ.size() > 0 && $urandom_range(0, 3) != 0) begin
            rvalid = 1'b1;
            rlast  = (beatQ[0] == 1);
        end else begin
            rvalid = 1'b0;
            rlast  = 1'($urandom);
        end
    endtask

    task automatic checkOutputs();
        bit open;
        open = arAllowed();
        for (int i = 0; i < 3; i++) begin
            chkVal($sformatf("grnt[%0d]", i), 64'(mGrnt[i]), 64'(owner == i));
            chkVal($sformatf("arready[%0d]", i), 64'(mArready[i]), 64'(owner == i && open && arready));
            chkVal($sformatf("rvalid[%0d]", i), 64'(mRvalid[i]), 64'(owner == i && rvalid));
        end
        if (owner >= 0) begin
            chkVal("bus_arvalid", 64'(arvalid), 64'(open && mArvalid[owner]));
            chkVal("bus_rready", 64'(rready), 64'(mRready[owner]));
            chkVal("bus_ar_payload", 64'({arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot}),
                   64'(masterAr(owner)));
            chkVal("owner_r_payload", 64'({mRid[owner], mRdata[owner], mRresp[owner], mRlast[owner]}),
                   64'({rid, rdata, rresp, rlast}));
        end else begin
            chkVal("bus_arvalid", 64'(arvalid), 64'(0));
            chkVal("bus_rready", 64'(rready), 64'(0));
            chkVal("bus_ar_payload", 64'({arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot}),
                   64'(0));
        end
    endtask

    // Advance the model across a rising edge using the values just driven.
    task automatic modelEdge();
        bit arHs, rBeat, rDone;
        arHs  = arAllowed() && mArvalid[owner] && arready;
        rBeat = owner >= 0 && rvalid && mRready[owner];
        rDone = rBeat && rlast;

        if (arHs) begin
            beatQ.push_back(int'(mArlen[owner]) + 1);
            issuing[owner] = 1'b0;
            burstsLeft[owner]--;
        end
        if (rBeat) begin
            beatQ[0] = beatQ[0] - 1;
            if (beatQ[0] == 0) void'(beatQ.pop_front());
        end

        if (owner < 0) begin
            if (holdOff > 0) begin
                holdOff--;
            end else if (mReq != 3'b000) begin
                owner     = arbitrate();
                lastGrant = owner;
            end
        end else if (!releasing) begin
            if (!mReq[owner]) begin
                if (inFlight == 0 && !arHs) begin
                    owner = -1; holdOff = 1;
                end else begin
                    releasing = 1'b1;
                end
            end
        end else if (inFlight == 0 || (inFlight == 1 && rDone)) begin
            owner = -1; releasing = 1'b0; holdOff = 1;
        end

        inFlight = inFlight + int'(arHs) - int'(rDone);
    endtask

    task automatic checkAllQuiet(input string tag);
        chkVal({tag, "_grnt"}, 64'(mGrnt), 64'(0));
        chkVal({tag, "_arvalid"}, 64'(arvalid), 64'(0));
        chkVal({tag, "_rready"}, 64'(rready), 64'(0));
        chkVal({tag, "_m_arready"}, 64'(mArready), 64'(0));
        chkVal({tag, "_m_rvalid"}, 64'(mRvalid), 64'(0));
        chkVal({tag, "_ar_payload"}, 64'({arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot}),
               64'(0));
    endtask

    task automatic resetModel();
        owner = -1; releasing = 1'b0; inFlight = 0; holdOff = 0; lastGrant = 0;
        beatQ.delete();
        for (int i = 0; i < 3; i++) begin
            issuing[i] = 1'b0;
            burstsLeft[i] = 0;
        end
    endtask

    // Asynchronous reset in the middle of traffic, then icache alone requests.
    task automatic midReset();
        @(negedge clk);
        rvalid  = 1'b1;
        arready = 1'b1;
        mArvalid = 3'b111;
        mRready  = 3'b111;
        #1;
        rst_n = 1'b0;
        #1;
        checkAllQuiet("midrst");
        @(posedge clk);
        #2;
        resetModel();
        mReq = 3'b001;
        burstsLeft[0] = 1;
        mArvalid = 3'b000;
        rvalid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        mReq = '0; mArvalid = '0; mRready = '0;
        for (int i = 0; i < 3; i++) randomAr(i);
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = '0; rdata = 32'hDEADBEEF; rresp = '0;
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllQuiet("reset");
        rvalid = 1'b0;
        rst_n = 1'b1;

        for (int cyc = 0; cyc < NCYCLE; cyc++) begin
            @(negedge clk);
            driveInputs();
            #1;
            checkOutputs();
            @(posedge clk);
            modelEdge();
            if (cyc == 1000 || cyc == 2000) midReset();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
